// File: rtl/uart_fifo_top.sv
// UART with 16x oversampled receiver, configurable frame format, TX/RX FIFOs
// and a runtime loopback path that feeds the internal TX line into the receiver.
module uart_fifo_top #(
  parameter int CLK_FRE    = 50000000,
  parameter int BAUD_RATE  = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [DATA_BITS-1:0] tx_data_i,
  input  logic                 tx_wr_i,
  output logic                 tx_full_o,
  output logic                 tx_busy_o,
  input  logic                 rx_i,
  output logic                 tx_o,
  input  logic                 loopback_i,
  output logic [DATA_BITS-1:0] rx_data_o,
  output logic                 rx_perr_o,
  output logic                 rx_ferr_o,
  input  logic                 rx_rd_i,
  output logic                 rx_empty_o,
  output logic                 rx_overrun_o
);
  localparam int DIV = CLK_FRE / (BAUD_RATE * 16);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int RW  = DATA_BITS + 2;
  localparam int BW  = $clog2(DATA_BITS);
  localparam logic ODD = (PARITY == 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  logic [CW-1:0] divCnt_q;
  logic          tick;

  assign tick = (divCnt_q == CW'(DIV - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)   divCnt_q <= '0;
    else if (tick) divCnt_q <= '0;
    else           divCnt_q <= divCnt_q + CW'(1);
  end

  // TX FIFO: a write while full is dropped even if the FSM pops in the same cycle
  logic [DATA_BITS-1:0] txMem_q [FIFO_DEPTH];
  logic [AW-1:0]        txWrPtr_q, txRdPtr_q;
  logic [AW:0]          txCount_q;
  logic                 txPush, txPop, txEmpty, txFull;
  logic [DATA_BITS-1:0] txHead;

  assign txFull  = (txCount_q == (AW+1)'(FIFO_DEPTH));
  assign txEmpty = (txCount_q == '0);
  assign txPush  = tx_wr_i && !txFull;
  assign txHead  = txMem_q[txRdPtr_q];

  always_ff @(posedge clk_i) begin
    if (txPush) txMem_q[txWrPtr_q] <= tx_data_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      txWrPtr_q <= '0;
      txRdPtr_q <= '0;
      txCount_q <= '0;
    end else begin
      if (txPush) txWrPtr_q <= txWrPtr_q + AW'(1);
      if (txPop)  txRdPtr_q <= txRdPtr_q + AW'(1);
      case ({txPush, txPop})
        2'b10:   txCount_q <= txCount_q + (AW+1)'(1);
        2'b01:   txCount_q <= txCount_q - (AW+1)'(1);
        default: txCount_q <= txCount_q;
      endcase
    end
  end

  logic [2:0]           txState_q, txState_d;
  logic [3:0]           txTick_q, txTick_d;
  logic [BW-1:0]        txBit_q, txBit_d;
  logic                 txStop_q, txStop_d;
  logic [DATA_BITS-1:0] txShift_q, txShift_d;
  logic                 txPar_q, txPar_d;
  logic                 txLine_q, txLine_d;
  logic                 txLoad;

  // txLoad covers both the first frame from idle and the no-gap reload after STOP
  always_comb begin
    txState_d = txState_q;
    txTick_d  = txTick_q;
    txBit_d   = txBit_q;
    txStop_d  = txStop_q;
    txShift_d = txShift_q;
    txPar_d   = txPar_q;
    txLine_d  = txLine_q;
    txPop     = 1'b0;
    txLoad    = 1'b0;
    case (txState_q)
      ST_IDLE: begin
        txLine_d = 1'b1;
        txLoad   = tick && !txEmpty;
      end
      ST_START, ST_DATA, ST_PARITY, ST_STOP: begin
        if (tick) begin
          txTick_d = txTick_q + 4'd1;
          if (txTick_q == 4'd15) begin
            case (txState_q)
              ST_START: begin
                txState_d = ST_DATA;
                txBit_d   = '0;
                txLine_d  = txShift_q[0];
              end
              ST_DATA: begin
                if (txBit_q == BW'(DATA_BITS - 1)) begin
                  if (PARITY != 0) begin
                    txState_d = ST_PARITY;
                    txLine_d  = txPar_q;
                  end else begin
                    txState_d = ST_STOP;
                    txStop_d  = 1'b0;
                    txLine_d  = 1'b1;
                  end
                end else begin
                  txBit_d   = txBit_q + BW'(1);
                  txShift_d = txShift_q >> 1;
                  txLine_d  = txShift_q[1];
                end
              end
              ST_PARITY: begin
                txState_d = ST_STOP;
                txStop_d  = 1'b0;
                txLine_d  = 1'b1;
              end
              default: begin
                if (txStop_q == 1'(STOP_BITS - 1)) begin
                  if (!txEmpty) begin
                    txLoad = 1'b1;
                  end else begin
                    txState_d = ST_IDLE;
                    txLine_d  = 1'b1;
                  end
                end else begin
                  txStop_d = 1'b1;
                end
              end
            endcase
          end
        end
      end
      default: txState_d = ST_IDLE;
    endcase
    if (txLoad) begin
      txPop     = 1'b1;
      txShift_d = txHead;
      txPar_d   = (^txHead) ^ ODD;
      txState_d = ST_START;
      txTick_d  = 4'd0;
      txLine_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      txState_q <= ST_IDLE;
      txTick_q  <= '0;
      txBit_q   <= '0;
      txStop_q  <= 1'b0;
      txShift_q <= '0;
      txPar_q   <= 1'b0;
      txLine_q  <= 1'b1;
    end else begin
      txState_q <= txState_d;
      txTick_q  <= txTick_d;
      txBit_q   <= txBit_d;
      txStop_q  <= txStop_d;
      txShift_q <= txShift_d;
      txPar_q   <= txPar_d;
      txLine_q  <= txLine_d;
    end
  end

  assign tx_o      = loopback_i ? 1'b1 : txLine_q;
  assign tx_busy_o = (txState_q != ST_IDLE) || !txEmpty;
  assign tx_full_o = txFull;

  logic rxLine, sync1_q, sync2_q;
  assign rxLine = loopback_i ? txLine_q : rx_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rxLine;
      sync2_q <= sync1_q;
    end
  end

  logic [2:0]           rxState_q, rxState_d;
  logic [3:0]           rxTick_q, rxTick_d;
  logic [BW-1:0]        rxBit_q, rxBit_d;
  logic [DATA_BITS-1:0] rxShift_q, rxShift_d;
  logic                 rxPerr_q, rxPerr_d;
  logic                 rxPush;

  // After the start-bit midpoint the 4-bit tick counter wraps every 16 ticks,
  // so every later sample lands on rxTick_q == 15.
  always_comb begin
    rxState_d = rxState_q;
    rxTick_d  = rxTick_q;
    rxBit_d   = rxBit_q;
    rxShift_d = rxShift_q;
    rxPerr_d  = rxPerr_q;
    rxPush    = 1'b0;
    case (rxState_q)
      ST_IDLE: begin
        if (tick && !sync2_q) begin
          rxState_d = ST_START;
          rxTick_d  = 4'd0;
        end
      end
      ST_START: begin
        if (tick) begin
          rxTick_d = rxTick_q + 4'd1;
          if (rxTick_q == 4'd7) begin
            if (sync2_q) begin
              rxState_d = ST_IDLE;
            end else begin
              rxState_d = ST_DATA;
              rxTick_d  = 4'd0;
              rxBit_d   = '0;
              rxPerr_d  = 1'b0;
            end
          end
        end
      end
      ST_DATA: begin
        if (tick) begin
          rxTick_d = rxTick_q + 4'd1;
          if (rxTick_q == 4'd15) begin
            rxShift_d = {sync2_q, rxShift_q[DATA_BITS-1:1]};
            if (rxBit_q == BW'(DATA_BITS - 1)) rxState_d = (PARITY != 0) ? ST_PARITY : ST_STOP;
            else                               rxBit_d   = rxBit_q + BW'(1);
          end
        end
      end
      ST_PARITY: begin
        if (tick) begin
          rxTick_d = rxTick_q + 4'd1;
          if (rxTick_q == 4'd15) begin
            rxPerr_d  = ((^rxShift_q) ^ sync2_q) != ODD;
            rxState_d = ST_STOP;
          end
        end
      end
      ST_STOP: begin
        if (tick) begin
          rxTick_d = rxTick_q + 4'd1;
          if (rxTick_q == 4'd15) begin
            rxPush    = 1'b1;
            rxState_d = ST_IDLE;
          end
        end
      end
      default: rxState_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rxState_q <= ST_IDLE;
      rxTick_q  <= '0;
      rxBit_q   <= '0;
      rxShift_q <= '0;
      rxPerr_q  <= 1'b0;
    end else begin
      rxState_q <= rxState_d;
      rxTick_q  <= rxTick_d;
      rxBit_q   <= rxBit_d;
      rxShift_q <= rxShift_d;
      rxPerr_q  <= rxPerr_d;
    end
  end

  // RX FIFO: a push into a full FIFO still lands if the head is popped that cycle
  logic [RW-1:0] rxMem_q [FIFO_DEPTH];
  logic [AW-1:0] rxWrPtr_q, rxRdPtr_q;
  logic [AW:0]   rxCount_q;
  logic          rxPop, rxWrite, rxDrop, rxEmpty, rxFull, rxOverrun_q;
  logic [RW-1:0] rxHead;

  assign rxFull  = (rxCount_q == (AW+1)'(FIFO_DEPTH));
  assign rxEmpty = (rxCount_q == '0);
  assign rxPop   = rx_rd_i && !rxEmpty;
  assign rxWrite = rxPush && (!rxFull || rxPop);
  assign rxDrop  = rxPush && rxFull && !rxPop;
  assign rxHead  = rxMem_q[rxRdPtr_q];

  always_ff @(posedge clk_i) begin
    if (rxWrite) rxMem_q[rxWrPtr_q] <= {!sync2_q, rxPerr_q, rxShift_q};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rxWrPtr_q   <= '0;
      rxRdPtr_q   <= '0;
      rxCount_q   <= '0;
      rxOverrun_q <= 1'b0;
    end else begin
      if (rxWrite) rxWrPtr_q <= rxWrPtr_q + AW'(1);
      if (rxPop)   rxRdPtr_q <= rxRdPtr_q + AW'(1);
      case ({rxWrite, rxPop})
        2'b10:   rxCount_q <= rxCount_q + (AW+1)'(1);
        2'b01:   rxCount_q <= rxCount_q - (AW+1)'(1);
        default: rxCount_q <= rxCount_q;
      endcase
      if (rxDrop)     rxOverrun_q <= 1'b1;
      else if (rxPop) rxOverrun_q <= 1'b0;
    end
  end

  assign rx_data_o    = rxEmpty ? '0 : rxHead[DATA_BITS-1:0];
  assign rx_perr_o    = !rxEmpty && rxHead[DATA_BITS];
  assign rx_ferr_o    = !rxEmpty && rxHead[DATA_BITS+1];
  assign rx_empty_o   = rxEmpty;
  assign rx_overrun_o = rxOverrun_q;

endmodule

// File: tb/tb_uart_fifo_top.sv
// Directed bench for uart_fifo_top: three instances cover 8N1 with a 4-deep FIFO,
// 8E2 transmit framing, and 8O1 receive error flags.
module tb_uart_fifo_top;
  logic clk;
  logic rstN;
  int   compareCount;
  int   mismatchCount;

  logic [7:0] txDataA, txDataB, txDataC;
  logic       txWrA, txWrB, txWrC;
  logic       txFullA, txFullB, txFullC;
  logic       txBusyA, txBusyB, txBusyC;
  logic       rxA, rxB, rxC;
  logic       txA, txB, txC;
  logic       loopA, loopB, loopC;
  logic [7:0] rxDataA, rxDataB, rxDataC;
  logic       rxPerrA, rxPerrB, rxPerrC;
  logic       rxFerrA, rxFerrB, rxFerrC;
  logic       rxRdA, rxRdB, rxRdC;
  logic       rxEmptyA, rxEmptyB, rxEmptyC;
  logic       rxOverrunA, rxOverrunB, rxOverrunC;
  logic       watchB;
  logic       txWatch;

  assign txWatch = watchB ? txB : txA;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  uart_fifo_top #(.CLK_FRE(1600000), .BAUD_RATE(100000), .DATA_BITS(8), .PARITY(0),
                  .STOP_BITS(1), .FIFO_DEPTH(4)) dutA (
    .clk_i(clk), .rst_ni(rstN), .tx_data_i(txDataA), .tx_wr_i(txWrA), .tx_full_o(txFullA),
    .tx_busy_o(txBusyA), .rx_i(rxA), .tx_o(txA), .loopback_i(loopA), .rx_data_o(rxDataA),
    .rx_perr_o(rxPerrA), .rx_ferr_o(rxFerrA), .rx_rd_i(rxRdA), .rx_empty_o(rxEmptyA),
    .rx_overrun_o(rxOverrunA));

  uart_fifo_top #(.CLK_FRE(1600000), .BAUD_RATE(100000), .DATA_BITS(8), .PARITY(2),
                  .STOP_BITS(2), .FIFO_DEPTH(16)) dutB (
    .clk_i(clk), .rst_ni(rstN), .tx_data_i(txDataB), .tx_wr_i(txWrB), .tx_full_o(txFullB),
    .tx_busy_o(txBusyB), .rx_i(rxB), .tx_o(txB), .loopback_i(loopB), .rx_data_o(rxDataB),
    .rx_perr_o(rxPerrB), .rx_ferr_o(rxFerrB), .rx_rd_i(rxRdB), .rx_empty_o(rxEmptyB),
    .rx_overrun_o(rxOverrunB));

  uart_fifo_top #(.CLK_FRE(1600000), .BAUD_RATE(100000), .DATA_BITS(8), .PARITY(1),
                  .STOP_BITS(1), .FIFO_DEPTH(16)) dutC (
    .clk_i(clk), .rst_ni(rstN), .tx_data_i(txDataC), .tx_wr_i(txWrC), .tx_full_o(txFullC),
    .tx_busy_o(txBusyC), .rx_i(rxC), .tx_o(txC), .loopback_i(loopC), .rx_data_o(rxDataC),
    .rx_perr_o(rxPerrC), .rx_ferr_o(rxFerrC), .rx_rd_i(rxRdC), .rx_empty_o(rxEmptyC),
    .rx_overrun_o(rxOverrunC));

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Pushes one word into the TX FIFO of instance 0 (A), 1 (B) or 2 (C)
  task automatic applyStimulus(input int which, input logic [7:0] data);
    @(negedge clk);
    case (which)
      0:       begin txDataA = data; txWrA = 1'b1; end
      1:       begin txDataB = data; txWrB = 1'b1; end
      default: begin txDataC = data; txWrC = 1'b1; end
    endcase
    @(negedge clk);
    txWrA = 1'b0;
    txWrB = 1'b0;
    txWrC = 1'b0;
  endtask

  task automatic popRx(input int which);
    @(negedge clk);
    if (which == 0) rxRdA = 1'b1;
    else            rxRdC = 1'b1;
    @(negedge clk);
    rxRdA = 1'b0;
    rxRdC = 1'b0;
  endtask

  // Drives n line bits, earliest bit in bits[n-1], each held 16 clocks
  task automatic sendSerial(input int which, input logic [11:0] bits, input int n);
    @(negedge clk);
    for (int i = n - 1; i >= 0; i--) begin
      if (which == 0) rxA = bits[i];
      else            rxC = bits[i];
      repeat (16) @(negedge clk);
    end
    rxA = 1'b1;
    rxC = 1'b1;
  endtask

  // Waits for a start bit on txWatch, then samples each bit near its middle
  task automatic checkFrame(input logic [23:0] bits, input int n, input string tag);
    int waited = 0;
    while (txWatch !== 1'b0 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    checkOutput({tag, " start seen"}, 16'(txWatch), 16'(1'b0));
    if (txWatch === 1'b0) begin
      repeat (8) @(negedge clk);
      for (int i = n - 1; i >= 0; i--) begin
        checkOutput($sformatf("%s %0d", tag, n - 1 - i), 16'(txWatch), 16'(bits[i]));
        repeat (16) @(negedge clk);
      end
    end
  endtask

  initial begin
    int waited;
    logic pinLow;
    compareCount  = 0;
    mismatchCount = 0;
    {txDataA, txDataB, txDataC} = '0;
    {txWrA, txWrB, txWrC} = '0;
    {rxRdA, rxRdB, rxRdC} = '0;
    {rxA, rxB, rxC} = 3'b111;
    loopA  = 1'b1;
    loopB  = 1'b0;
    loopC  = 1'b0;
    watchB = 1'b0;
    rstN   = 1'b1;
    #2 rstN = 1'b0;
    repeat (3) @(negedge clk);

    checkOutput("reset txB", 16'(txB), 16'(1'b1));
    checkOutput("reset txC", 16'(txC), 16'(1'b1));
    checkOutput("reset txFullA", 16'(txFullA), 16'(1'b0));
    checkOutput("reset txBusyA", 16'(txBusyA), 16'(1'b0));
    checkOutput("reset txFullC", 16'(txFullC), 16'(1'b0));
    checkOutput("reset txBusyC", 16'(txBusyC), 16'(1'b0));
    checkOutput("reset rxEmptyA", 16'(rxEmptyA), 16'(1'b1));
    checkOutput("reset rxDataA", 16'(rxDataA), 16'(8'h00));
    checkOutput("reset rxPerrA", 16'(rxPerrA), 16'(1'b0));
    checkOutput("reset rxFerrA", 16'(rxFerrA), 16'(1'b0));
    checkOutput("reset rxOverrunA", 16'(rxOverrunA), 16'(1'b0));
    checkOutput("reset rxB flags", 16'({rxDataB, rxPerrB, rxFerrB, rxOverrunB}), 16'(0));
    rstN = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] test 1: loopback 8N1 word 0xA5");
    applyStimulus(0, 8'hA5);
    pinLow = 1'b0;
    waited = 0;
    while (rxEmptyA && waited < 400) begin
      if (txA !== 1'b1) pinLow = 1'b1;
      @(negedge clk);
      waited++;
    end
    checkOutput("t1 tx pin held high", 16'(pinLow), 16'(1'b0));
    checkOutput("t1 latency near 10 bits", 16'(waited >= 140 && waited <= 175), 16'(1'b1));
    checkOutput("t1 rx data", 16'(rxDataA), 16'(8'hA5));
    checkOutput("t1 perr", 16'(rxPerrA), 16'(1'b0));
    checkOutput("t1 ferr", 16'(rxFerrA), 16'(1'b0));
    popRx(0);
    checkOutput("t1 empty after rd", 16'(rxEmptyA), 16'(1'b1));
    checkOutput("t1 data zero when empty", 16'(rxDataA), 16'(8'h00));

    $display("[TB] test 2: 8E2 framing, two frames back-to-back");
    watchB = 1'b1;
    applyStimulus(1, 8'h3C);
    fork
      checkFrame({12'b000111100011, 12'b011000011011}, 24, "t2 bit");
      begin
        repeat (20) @(negedge clk);
        applyStimulus(1, 8'hC3);
      end
    join
    checkOutput("t2 busy after frames", 16'(txBusyB), 16'(1'b0));
    checkOutput("t2 rxB stays empty", 16'(rxEmptyB), 16'(1'b1));
    watchB = 1'b0;

    $display("[TB] test 3: 8O1 receive with parity and framing errors");
    sendSerial(2, 12'b0_01010101001, 11);
    sendSerial(2, 12'b0_01111000010, 11);
    repeat (30) @(negedge clk);
    checkOutput("t3 not empty", 16'(rxEmptyC), 16'(1'b0));
    checkOutput("t3 head1 data", 16'(rxDataC), 16'(8'h55));
    checkOutput("t3 head1 perr", 16'(rxPerrC), 16'(1'b1));
    checkOutput("t3 head1 ferr", 16'(rxFerrC), 16'(1'b0));
    popRx(2);
    checkOutput("t3 head2 data", 16'(rxDataC), 16'(8'h0F));
    checkOutput("t3 head2 perr", 16'(rxPerrC), 16'(1'b0));
    checkOutput("t3 head2 ferr", 16'(rxFerrC), 16'(1'b1));

    $display("[TB] test 4: FIFO full and RX overrun with depth 4");
    applyStimulus(0, 8'h11);
    applyStimulus(0, 8'h22);
    applyStimulus(0, 8'h33);
    applyStimulus(0, 8'h44);
    applyStimulus(0, 8'h55);
    applyStimulus(0, 8'h66);
    checkOutput("t4 tx full", 16'(txFullA), 16'(1'b1));
    waited = 0;
    while (txBusyA && waited < 1500) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("t4 tx drained", 16'(txBusyA), 16'(1'b0));
    repeat (20) @(negedge clk);
    checkOutput("t4 overrun set", 16'(rxOverrunA), 16'(1'b1));
    checkOutput("t4 head first word", 16'(rxDataA), 16'(8'h11));
    popRx(0);
    checkOutput("t4 overrun cleared", 16'(rxOverrunA), 16'(1'b0));
    checkOutput("t4 head second word", 16'(rxDataA), 16'(8'h22));
    popRx(0);
    checkOutput("t4 head third word", 16'(rxDataA), 16'(8'h33));
    popRx(0);
    checkOutput("t4 head fourth word", 16'(rxDataA), 16'(8'h44));
    popRx(0);
    checkOutput("t4 fifth word dropped", 16'(rxEmptyA), 16'(1'b1));

    $display("[TB] test 5: start-bit glitch rejection");
    loopA = 1'b0;
    repeat (4) @(negedge clk);
    rxA = 1'b0;
    repeat (4) @(negedge clk);
    rxA = 1'b1;
    repeat (40) @(negedge clk);
    checkOutput("t5 glitch ignored", 16'(rxEmptyA), 16'(1'b1));
    sendSerial(0, 12'b00_0100000011, 10);
    repeat (10) @(negedge clk);
    checkOutput("t5 frame received", 16'(rxEmptyA), 16'(1'b0));
    checkOutput("t5 data", 16'(rxDataA), 16'(8'h81));
    checkOutput("t5 flags", 16'({rxPerrA, rxFerrA}), 16'(2'b00));
    popRx(0);

    $display("[TB] test 6: reset in the middle of a frame");
    applyStimulus(0, 8'h00);
    applyStimulus(0, 8'h77);
    repeat (70) @(negedge clk);
    checkOutput("t6 tx low at data bit 3", 16'(txA), 16'(1'b0));
    rstN = 1'b0;
    #1;
    checkOutput("t6 tx high in reset", 16'(txA), 16'(1'b1));
    checkOutput("t6 busy cleared", 16'(txBusyA), 16'(1'b0));
    checkOutput("t6 tx fifo not full", 16'(txFullA), 16'(1'b0));
    checkOutput("t6 rx empty", 16'(rxEmptyA), 16'(1'b1));
    repeat (3) @(negedge clk);
    rstN = 1'b1;
    repeat (30) @(negedge clk);
    checkOutput("t6 idle after release", 16'({txA, txBusyA}), 16'(2'b10));
    applyStimulus(0, 8'hA5);
    checkFrame({14'b0, 10'b0101001011}, 10, "t6 bit");
    checkOutput("t6 busy after frame", 16'(txBusyA), 16'(1'b0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end
endmodule

// File: doc/uart_fifo_top.md
Name: uart_fifo_top

Overview:
Parametrised UART with 16x-oversampling receiver, configurable frame format, and TX/RX FIFOs.
It replaces the fixed 8N1, unbuffered UART top.
It sits between a register or bus front-end and the serial pins.
A runtime loopback mode routes TX to RX internally for self-test.

Parameters:
CLK_FRE, 50000000, system clock frequency in Hz.
BAUD_RATE, 115200, line rate. Oversample divisor DIV = CLK_FRE/(BAUD_RATE*16), integer-truncated, must be >= 1.
DATA_BITS, 8, data bits per frame, legal range 5..8.
PARITY, 0, parity mode: 0 none, 1 odd, 2 even.
STOP_BITS, 1, stop bits, 1 or 2.
FIFO_DEPTH, 16, entries per FIFO, power of two, >= 2.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
tx_data  in  DATA_BITS  word to transmit
tx_wr  in  1  write strobe; pushes tx_data when tx_full=0
tx_full  out  1  TX FIFO full
tx_busy  out  1  high while a frame is on the line or the TX FIFO is non-empty
rx  in  1  serial input, asynchronous to clk
tx  out  1  serial output
loopback  in  1  1 = RX sourced from internal TX line, tx pin held 1
rx_data  out  DATA_BITS  head of RX FIFO (show-ahead), 0 when rx_empty
rx_perr  out  1  parity error flag of the head word
rx_ferr  out  1  framing error flag of the head word
rx_rd  in  1  pop strobe; ignored when rx_empty=1
rx_empty  out  1  RX FIFO empty
rx_overrun  out  1  sticky: a received word was dropped

Behaviour:
- Reset (async assert, sync release) state:
  - tx=1, tx_full=0, tx_busy=0, rx_empty=1, rx_data=0, rx_perr=0, rx_ferr=0, rx_overrun=0.
  - FIFOs empty, both FSMs idle, oversample counter 0.
  - Reset mid-frame aborts the frame; tx returns to 1 immediately.
- Oversample tick:
  - Free-running counter 0..DIV-1.
  - tick is a single-cycle pulse when the counter wraps.
  - One bit period = 16 ticks.
- TX FSM: IDLE -> START -> DATA -> PARITY (skipped if PARITY=0) -> STOP -> IDLE, or back to START if the FIFO is non-empty (back-to-back frames, no idle gap).
  - In IDLE with the FIFO non-empty, pop the head on the next tick and enter START.
  - Each state lasts 16 ticks; STOP lasts 16*STOP_BITS ticks.
  - Data is sent LSB first.
  - Parity is XOR of the data bits: odd mode inverts it, even mode does not.
  - tx is registered.
- TX FIFO:
  - A push when full is ignored, even if a pop occurs in the same cycle.
  - Push and pop in the same cycle when not full or empty keeps the count unchanged.
- RX input:
  - Line = loopback ? internal tx : rx, passed through a 2-FF synchronizer.
- RX FSM: IDLE -> START -> DATA -> PARITY (if enabled) -> STOP -> IDLE.
  - IDLE: a low synchronized line on a tick starts the tick count.
  - START: resample at tick 8. If the line is high, treat it as a glitch and return to IDLE.
  - Subsequent bits are sampled every 16 ticks from the start-bit midpoint.
  - Parity mismatch sets perr; a low first stop bit sets ferr. Only the first stop bit is checked.
  - On the stop sample, push {ferr, perr, data} into the RX FIFO, then return to IDLE; a new start is accepted from the next tick.
- RX FIFO full at push:
  - The word is dropped and rx_overrun is set.
  - rx_overrun clears on the next accepted rx_rd; set wins if set and clear coincide.
- rx_data, rx_perr and rx_ferr reflect the head entry combinationally from registered storage and are 0 when empty.
- A same-cycle RX push and rx_rd on a full FIFO is accepted: the count is unchanged and there is no overrun.
- Loopback change mid-frame is undefined; the bench changes it only when idle.
- Throughput: continuous TX at full line rate; RX sustains back-to-back frames.

Test Plan:
1. Sim params CLK_FRE=1600000, BAUD_RATE=100000 (DIV=1, 16 clk/bit), 8N1, loopback=1. Write 0xA5 -> tx pin stays 1; after 10 bit periods rx_empty=0, rx_data=0xA5, perr=0, ferr=0; rx_rd -> rx_empty=1.
2. loopback=0, PARITY=2, STOP_BITS=2. Write 0x3C -> tx shows 0, 0,0,1,1,1,1,0,0, 0 (parity), 1,1, with each bit held 16 clk, frames back-to-back when 2 words are queued.
3. Drive rx with 0x55 and a wrong parity bit (PARITY=1), then 0x0F with stop=0 -> head1 perr=1 ferr=0; head2 ferr=1, data=0x0F.
4. FIFO_DEPTH=4, loopback=1. Write 6 words quickly -> tx_full after 4 unsent entries, extra writes dropped; send 5 frames without rx_rd -> 4 stored, rx_overrun=1; one rx_rd -> rx_overrun=0.
5. Drive a 4-clk low glitch on rx -> no word received, FSM back in IDLE, next valid frame 0x81 received correctly.
6. Assert reset mid-TX-frame (bit 3) -> tx=1 at once, FIFOs empty, tx_busy=0; after release, a new write transmits cleanly.
